// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: drives the PLL reset/power-down pins, qualifies
// lock through a stability window, releases the downstream system reset,
// and re-cycles the PLL on lock loss or lock timeout (bounded retries).
// Ports:
//   clk, rst_n        reference clock, async active-low reset
//   pll_lock          PLL lock (asynchronous, synchronised internally)
//   pwd_req           level power-down request
//   restart           pulse that leaves FAIL
//   pll_rst, pll_pwd  PLL control pins (active high)
//   sys_rst_n         downstream reset, released only in RUN
//   ready, fail       RUN / FAIL status
//   retry_cnt         timeout retries in the current bring-up
//   loss_cnt          saturating lock-loss event count
//   state             encoded FSM state for debug
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       pwd_req,
  input  logic       restart,
  output logic       pll_rst,
  output logic       pll_pwd,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_PWD       = 3'd0;
  localparam logic [2:0] S_PLL_RST   = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_STABLE    = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  logic             lock_m;
  logic             lock_s;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [2:0]       state_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;

  // Two-flop synchroniser for the asynchronous lock output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // State, timer and counter registers; outputs decoded from the next state
  // so they change on the same edge as the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLL_RST;
      timer     <= '0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      pll_pwd   <= 1'b0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      pll_rst   <= (state_nxt == S_PLL_RST) || (state_nxt == S_PWD);
      pll_pwd   <= (state_nxt == S_PWD);
      sys_rst_n <= (state_nxt == S_RUN);
      ready     <= (state_nxt == S_RUN);
      fail      <= (state_nxt == S_FAIL);
    end
  end

  // Next-state logic; in RUN the timer doubles as the lock-loss filter
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + CNT_W'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    if (pwd_req) begin
      state_nxt = S_PWD;
      timer_nxt = timer;
    end else begin
      case (state)
        S_PWD: begin
          state_nxt = S_PLL_RST;
          retry_nxt = 4'd0;
        end
        S_PLL_RST: begin
          if (timer == RST_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = S_STABLE;
          end else if (timer == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = S_FAIL;
            end else begin
              state_nxt = S_PLL_RST;
              retry_nxt = retry_cnt + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            state_nxt = S_RUN;
            retry_nxt = 4'd0;
          end
        end
        S_RUN: begin
          if (lock_s) begin
            timer_nxt = '0;
          end else if (timer == LOSS_LAST) begin
            state_nxt = S_PLL_RST;
            if (loss_cnt != 8'd255) loss_nxt = loss_cnt + 8'd1;
          end
        end
        S_FAIL: begin
          timer_nxt = timer;
          if (restart) begin
            state_nxt = S_PLL_RST;
            retry_nxt = 4'd0;
          end
        end
        default: state_nxt = S_PLL_RST;
      endcase
    end
    if (state_nxt != state) timer_nxt = '0;
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: directed stimulus pushes the
// expected state transitions (edge number, state, counters) into a queue;
// a monitor pops and compares on every observed state change.
module tb_pll_lock_sequencer;

  localparam logic [2:0] S_PWD = 3'd0, S_PLL_RST = 3'd1, S_WAIT = 3'd2,
                         S_STABLE = 3'd3, S_RUN = 3'd4, S_FAIL = 3'd5;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [3:0] retry;
    logic [7:0] loss;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pwd_req = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, pll_pwd, sys_rst_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
    .LOSS_FILTER(3), .MAX_RETRY(2), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pwd_req(pwd_req),
    .restart(restart), .pll_rst(pll_rst), .pll_pwd(pll_pwd),
    .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int at, logic [2:0] st, logic [3:0] r, logic [7:0] l);
    exp_t e;
    e.at = at; e.st = st; e.retry = r; e.loss = l;
    sb.push_back(e);
  endfunction

  // Output pins implied by a state: {pll_rst, pll_pwd, sys_rst_n, ready, fail}
  function automatic logic [4:0] pins_for(logic [2:0] st);
    case (st)
      S_PWD:   return 5'b11000;
      S_PLL_RST: return 5'b10000;
      S_RUN:   return 5'b00110;
      S_FAIL:  return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // {state, pins, retry, loss} as a flat vector
  function automatic logic [31:0] outs();
    return 32'({state, pll_rst, pll_pwd, sys_rst_n, ready, fail, retry_cnt, loss_cnt});
  endfunction

  localparam logic [31:0] RESET_OUTS = 32'({3'd1, 5'b10000, 4'd0, 8'd0});

  // Monitor: every state change must match the head of the scoreboard
  initial begin : monitor
    logic [2:0] prev;
    exp_t       e;
    prev = S_PLL_RST;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = state;
      end else if (state != prev) begin
        prev = state;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: edge=%0d state=%0d retry=%0d loss=%0d",
                   cyc, state, retry_cnt, loss_cnt);
        end else begin
          e = sb.pop_front();
          if (cyc != e.at || state !== e.st || retry_cnt !== e.retry ||
              loss_cnt !== e.loss ||
              {pll_rst, pll_pwd, sys_rst_n, ready, fail} !== pins_for(e.st)) begin
            errors++;
            $display("FAIL transition: got edge=%0d st=%0d pins=%b retry=%0d loss=%0d, expected edge=%0d st=%0d pins=%b retry=%0d loss=%0d",
                     cyc, state, {pll_rst, pll_pwd, sys_rst_n, ready, fail}, retry_cnt, loss_cnt,
                     e.at, e.st, pins_for(e.st), e.retry, e.loss);
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for all pushed transitions to be observed
  task automatic drain(string name, int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d transitions still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin : stim
    int c;
    #1 rst_n = 1'b0;
    #2 chk("reset_values", outs(), RESET_OUTS);
    step(2);
    chk("reset_held", outs(), RESET_OUTS);

    // 1: bring-up, lock 10 cycles after release
    c = cyc;
    push(c + 4, S_WAIT, 4'd0, 8'd0);
    rst_n = 1'b1;
    step(10);
    c = cyc;
    pll_lock = 1'b1;
    push(c + 3, S_STABLE, 4'd0, 8'd0);
    push(c + 11, S_RUN, 4'd0, 8'd0);
    drain("t1", 40);

    // 2: 2-cycle glitch ignored, 3-cycle drop re-cycles the PLL
    step(2);
    pll_lock = 1'b0;
    step(2);
    pll_lock = 1'b1;
    step(5);
    c = cyc;
    pll_lock = 1'b0;
    push(c + 5, S_PLL_RST, 4'd0, 8'd1);
    push(c + 9, S_WAIT, 4'd0, 8'd1);
    push(c + 10, S_STABLE, 4'd0, 8'd1);
    push(c + 18, S_RUN, 4'd0, 8'd1);
    step(3);
    pll_lock = 1'b1;
    drain("t2", 40);

    // 3: persistent loss, retries exhausted, FAIL, restart
    step(2);
    c = cyc;
    pll_lock = 1'b0;
    push(c + 5, S_PLL_RST, 4'd0, 8'd2);
    push(c + 9, S_WAIT, 4'd0, 8'd2);
    push(c + 29, S_PLL_RST, 4'd1, 8'd2);
    push(c + 33, S_WAIT, 4'd1, 8'd2);
    push(c + 53, S_PLL_RST, 4'd2, 8'd2);
    push(c + 57, S_WAIT, 4'd2, 8'd2);
    push(c + 77, S_FAIL, 4'd2, 8'd2);
    drain("t3", 150);
    step(3);
    chk("fail_hold", outs(), 32'({S_FAIL, 5'b00001, 4'd2, 8'd2}));
    c = cyc;
    restart = 1'b1;
    push(c + 1, S_PLL_RST, 4'd0, 8'd2);
    push(c + 5, S_WAIT, 4'd0, 8'd2);
    step(1);
    restart = 1'b0;
    step(5);

    // 4: lock glitch at stable count 5 restarts qualification
    c = cyc;
    pll_lock = 1'b1;
    push(c + 3, S_STABLE, 4'd0, 8'd2);
    push(c + 9, S_WAIT, 4'd0, 8'd2);
    push(c + 10, S_STABLE, 4'd0, 8'd2);
    push(c + 18, S_RUN, 4'd0, 8'd2);
    step(6);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    drain("t4", 40);

    // 5: power-down from RUN, restart ignored while powered down
    step(2);
    c = cyc;
    pwd_req = 1'b1;
    push(c + 1, S_PWD, 4'd0, 8'd2);
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(2);
    pwd_req = 1'b0;
    push(c + 6, S_PLL_RST, 4'd0, 8'd2);
    push(c + 10, S_WAIT, 4'd0, 8'd2);
    push(c + 11, S_STABLE, 4'd0, 8'd2);
    push(c + 19, S_RUN, 4'd0, 8'd2);
    drain("t5", 40);

    // 6: async reset while waiting for lock with retry_cnt=1
    step(2);
    c = cyc;
    pll_lock = 1'b0;
    push(c + 5, S_PLL_RST, 4'd0, 8'd3);
    push(c + 9, S_WAIT, 4'd0, 8'd3);
    push(c + 29, S_PLL_RST, 4'd1, 8'd3);
    push(c + 33, S_WAIT, 4'd1, 8'd3);
    drain("t6", 80);
    step(2);
    chk("pre_reset_wait", outs(), 32'({S_WAIT, 5'b00000, 4'd1, 8'd3}));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), RESET_OUTS);
    step(2);
    chk("async_reset_held", outs(), RESET_OUTS);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the system PLL primitive from a free-running reference clock: drives its reset and power-down pins and watches its lock output.
- Qualifies lock with a stability window, then releases the downstream system reset.
- On lock loss it re-asserts system reset and re-cycles the PLL. On repeated lock timeouts it retries a bounded number of times, then latches a failure flag.
- Sits between the board reset/reference clock and the PLL wrapper. Its outputs feed the per-domain reset synchronisers of the clkout domains.

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per PLL reset attempt (>=1)
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before an attempt is declared failed (>=2)
- STABLE_CYCLES, 1024, consecutive synced-lock cycles required before system reset release (>=1)
- LOSS_FILTER, 4, consecutive synced-lock-low cycles in RUN treated as real lock loss (>=1)
- MAX_RETRY, 3, PLL re-reset attempts after a timeout before entering FAIL (0..15)
- CNT_W, 20, timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
- clk  in  1  free-running reference clock (PLL input clock)
- rst_n  in  1  asynchronous active-low reset
- pll_lock  in  1  PLL lock output; asynchronous to clk
- pwd_req  in  1  level request to power the PLL down; synchronous to clk
- restart  in  1  single-cycle pulse; leaves FAIL only
- pll_rst  out  1  PLL reset, active high
- pll_pwd  out  1  PLL power-down, active high
- sys_rst_n  out  1  downstream reset, active low
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- retry_cnt  out  4  timeout retries in the current bring-up
- loss_cnt  out  8  lock-loss events since rst_n; saturates at 255
- state  out  3  encoded state for debug: PWD=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear asynchronously on rst_n=0.
- Reset values: state=PLL_RST, timer=0, pll_rst=1, pll_pwd=0, sys_rst_n=0, ready=0, fail=0, retry_cnt=0, loss_cnt=0, lock sync flops=0.
- Lock synchroniser: pll_lock passes through two flops to give lock_s, a 2-cycle latency. No logic uses raw pll_lock.
- Output decode: all outputs are registered and decoded from the state register.
  - pll_rst=1 in PLL_RST and PWD.
  - pll_pwd=1 in PWD only.
  - sys_rst_n=1 in RUN only.
- The timer clears on every state transition.
- PLL_RST: timer counts up. When timer==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high exactly RST_CYCLES cycles.
- WAIT_LOCK: timer counts up.
  - lock_s=1: go to STABLE.
  - Otherwise, when timer==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY go to FAIL; else retry_cnt+1 and go to PLL_RST.
  - lock_s=1 takes priority over timeout in the same cycle.
- STABLE: timer counts consecutive lock_s=1 cycles.
  - lock_s=0: go back to WAIT_LOCK with a fresh timer; retry_cnt is unchanged.
  - When timer==STABLE_CYCLES-1 with lock_s=1: go to RUN and clear retry_cnt.
- RUN: a loss counter counts consecutive lock_s=0 cycles and clears whenever lock_s=1.
  - When it reaches LOSS_FILTER: loss_cnt+1 (saturating) and go to PLL_RST. sys_rst_n falls on that same edge.
  - Glitches shorter than LOSS_FILTER cycles have no effect.
- FAIL: holds pll_rst=0 and sys_rst_n=0.
  - restart=1: retry_cnt=0 and go to PLL_RST.
  - restart is ignored in every other state.
- PWD: entered from any state on the edge pwd_req=1 is sampled. pwd_req has priority over every other condition.
  - Stays in PWD while pwd_req=1.
  - On pwd_req=0: retry_cnt=0 and go to PLL_RST.
- End-to-end latency: pll_lock rising before edge k gives state=STABLE at edge k+2 and sys_rst_n=1 at edge k+2+STABLE_CYCLES, provided lock is held.
- rst_n assertion mid-operation returns immediately to the reset values. loss_cnt is not preserved.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_FILTER=3, MAX_RETRY=2.
1. Release rst_n, raise pll_lock 10 cycles later -> pll_rst high 4 cycles; state=STABLE 2 edges after lock sampled; sys_rst_n=1 and ready=1 exactly 10 edges after lock sampled; retry_cnt=0.
2. In RUN, drop pll_lock for 2 cycles, then for 3 cycles -> first drop: no change. Second drop: sys_rst_n=0 on the 3rd synced-low cycle; loss_cnt=1; pll_rst high 4 cycles; RUN re-entered once lock returns.
3. Keep pll_lock=0 -> three 20-cycle WAIT_LOCK windows with retry_cnt 0,1,2; fail=1 and state=5 after the third; pll_rst=0. Pulse restart -> retry_cnt=0, state=PLL_RST.
4. In STABLE, pulse pll_lock low for 1 cycle at stable count 5 -> return to WAIT_LOCK; RUN only after 8 further consecutive lock cycles.
5. Assert pwd_req in RUN -> next edge pll_pwd=1, pll_rst=1, sys_rst_n=0. Deassert -> PLL_RST, full bring-up repeats. A restart pulse during PWD is ignored.
6. Assert rst_n=0 in WAIT_LOCK with retry_cnt=1 -> all outputs return to their reset values asynchronously, with no clock edge needed.
